// File: rtl/mixed_apb_initiator_if.sv
// rtl/mixed_apb_initiator_if.sv - command, response and APB signal bundle for mixed_apb_initiator
interface mixed_apb_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, rsp_rdy, prdata, pready, pslverr,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_vld, cmd_write, cmd_addr, cmd_wdata, rsp_rdy, prdata, pready, pslverr,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/mixed_apb_initiator.sv
// rtl/mixed_apb_initiator.sv - single-outstanding APB master fed by a ready/valid command channel
module mixed_apb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mixed_apb_initiator_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              timeout_hit;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              rsp_vld_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  assign wait_cnt_d  = wait_cnt_q + CNT_W'(1);
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_vld_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_vld) begin
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
            pwrite_q <= bus.cmd_write;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready is checked first so a completion on the limit cycle is not an abort
          if (bus.pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_vld_q     <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (timeout_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_vld_q     <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_RESP: begin
          if (bus.rsp_rdy) begin
            rsp_vld_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy     = rst_n & (state_q == S_IDLE);
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.paddr       = paddr_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_mixed_apb_initiator.sv
// tb/tb_mixed_apb_initiator.sv - scoreboard bench for mixed_apb_initiator with TIMEOUT = 8
module tb_mixed_apb_initiator;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  rsp_t sb_q[$];

  mixed_apb_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mixed_apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rd, input logic slverr,
                         input int hold, input string name);
    rsp_t exp;
    rsp_t got;
    int   acc;
    if (waits < TIMEOUT) begin
      exp.rdata = wr ? 32'h0 : rd;
      exp.err   = slverr;
      exp.to    = 1'b0;
    end else begin
      exp.rdata = 32'h0;
      exp.err   = 1'b1;
      exp.to    = 1'b1;
    end
    sb_q.push_back(exp);

    checks++;
    if (bus.cmd_rdy !== 1'b1) begin failures++; $display("FAIL %s.cmd_rdy_idle got=%b exp=1", name, bus.cmd_rdy); end
    bus.cmd_vld = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0; bus.cmd_write = ~wr; bus.cmd_addr = ~addr; bus.cmd_wdata = ~wdata;

    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 1'b0, wr, addr, wdata}) begin
      failures++;
      $display("FAIL %s.setup got=%b%b%b %h %h exp=10%b %h %h", name, bus.psel, bus.penable, bus.pwrite,
               bus.paddr, bus.pwdata, wr, addr, wdata);
    end
    @(posedge clk); #1;

    acc = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++;
      if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 1'b1, wr, addr, wdata}) begin
        failures++;
        $display("FAIL %s.access%0d got=%b%b%b %h %h exp=11%b %h %h", name, i, bus.psel, bus.penable,
                 bus.pwrite, bus.paddr, bus.pwdata, wr, addr, wdata);
      end
      acc++;
      if (i == waits) begin
        bus.pready = 1'b1; bus.prdata = rd; bus.pslverr = slverr;
      end else begin
        bus.prdata = $urandom; bus.pslverr = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'b0;
      if (i == waits) break;
    end

    checks++;
    if (acc !== ((waits < TIMEOUT) ? waits + 1 : TIMEOUT)) begin
      failures++; $display("FAIL %s.access_cycles got=%0d exp=%0d", name, acc, (waits < TIMEOUT) ? waits + 1 : TIMEOUT);
    end

    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL %s.sb_empty got=0 exp=1", name);
    end else begin
      got = sb_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if ({bus.rsp_vld, bus.psel, bus.penable, bus.cmd_rdy, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}
            !== {1'b1, 1'b0, 1'b0, 1'b0, got.rdata, got.err, got.to}) begin
          failures++;
          $display("FAIL %s.resp%0d got=vld%b sel%b en%b rdy%b %h e%b t%b exp=vld1 sel0 en0 rdy0 %h e%b t%b",
                   name, h, bus.rsp_vld, bus.psel, bus.penable, bus.cmd_rdy, bus.rsp_rdata, bus.rsp_err,
                   bus.rsp_timeout, got.rdata, got.err, got.to);
        end
        if (h < hold) begin
          bus.cmd_vld = 1'b1;
          @(posedge clk); #1;
        end
      end
    end

    bus.cmd_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b0;
    checks++;
    if ({bus.rsp_vld, bus.cmd_rdy, bus.psel} !== 3'b010) begin
      failures++; $display("FAIL %s.after_rsp got=vld%b rdy%b sel%b exp=vld0 rdy1 sel0", name, bus.rsp_vld, bus.cmd_rdy, bus.psel);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_rdy, bus.rsp_vld, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.paddr, bus.psel,
         bus.penable, bus.pwrite, bus.pwdata} !== '0) begin
      failures++;
      $display("FAIL reset.outputs got=rdy%b vld%b sel%b en%b paddr%h exp=all zero", bus.cmd_rdy, bus.rsp_vld,
               bus.psel, bus.penable, bus.paddr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset.cmd_rdy got=%b exp=1", bus.cmd_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_zero_wait();
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h1234_5678, 1'b0, 0, "write0");
  endtask

  task automatic test_read_wait();
    do_xfer(1'b0, 32'h04, 32'h0, 3, 32'h0000_A5A5, 1'b0, 0, "read_wait3");
  endtask

  task automatic test_read_slverr();
    do_xfer(1'b0, 32'h08, 32'h0, 1, 32'hCAFE_0001, 1'b1, 0, "read_slverr");
    do_xfer(1'b1, 32'h0C, 32'h5555_AAAA, 0, 32'h0, 1'b0, 0, "write_after_err");
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 32'h40, 32'h0, TIMEOUT, 32'hFFFF_FFFF, 1'b0, 0, "timeout_abort");
    do_xfer(1'b0, 32'h44, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D, 1'b0, 0, "timeout_edge_ready");
  endtask

  task automatic test_rsp_backpressure();
    do_xfer(1'b0, 32'h80, 32'h0, 2, 32'h1357_9BDF, 1'b0, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    do_xfer(1'b1, 32'h100, 32'h0000_0001, 0, 32'h0, 1'b0, 0, "b2b_a");
    do_xfer(1'b0, 32'h104, 32'h0, 0, 32'h0000_0002, 1'b0, 0, "b2b_b");
    checks++;
    if ((cyc - start) !== 8) begin failures++; $display("FAIL b2b.cycles got=%0d exp=8", cyc - start); end
  endtask

  task automatic test_reset_mid_access();
    bus.cmd_vld = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h0;
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_vld, bus.cmd_rdy} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid.async got=sel%b en%b vld%b rdy%b exp=0000", bus.psel, bus.penable, bus.rsp_vld, bus.cmd_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin failures++; $display("FAIL rst_mid.cmd_rdy got=%b exp=1", bus.cmd_rdy); end
    bus.pready = 1'b1; bus.prdata = 32'hDEAD_0000;
    @(posedge clk); #1;
    bus.pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.rsp_vld, bus.psel} !== 2'b00) begin
        failures++; $display("FAIL rst_mid.stale%0d got=vld%b sel%b exp=00", i, bus.rsp_vld, bus.psel);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.cmd_vld = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_rdy = 1'b0; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_read_slverr();
    test_timeout();
    test_rsp_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    checks++;
    if (sb_q.size() !== 0) begin failures++; $display("FAIL sb.leftover got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mixed_apb_initiator.md
Name: mixed_apb_initiator

Overview:
- Bus master that drives the APB register port of a register-bearing block, for example the blockARegs decode on apbReg.
- Accepts one register command at a time on a ready/valid command channel and runs it as an APB SETUP/ACCESS transfer.
- Returns read data and error status on a ready/valid response channel.
- Sits in a testbench or a control block in front of any apb_if.dst consumer; one outstanding transfer at a time.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 255, max ACCESS cycles without pready before abort (1..65535)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, asynchronous assert, active-low, named as the codebase does
cmd_vld  input  1  command valid
cmd_rdy  output  1  command ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  register address
cmd_wdata  input  DATA_W  write data
rsp_vld  output  1  response valid
rsp_rdy  input  1  response ready
rsp_rdata  output  DATA_W  read data (0 for writes and aborted transfers)
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  transfer aborted by timeout
paddr  output  ADDR_W  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset (rst_n low, async): state IDLE.
  - All outputs 0 except cmd_rdy = 1 once rst_n is high and state is IDLE.
  - Counter cleared.
  - psel drops immediately, even mid-transfer; an in-flight transfer is abandoned and no response is produced.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_rdy = 1.
  - On cmd_vld & cmd_rdy: register cmd_write/addr/wdata onto pwrite/paddr/pwdata, go to SETUP.
- SETUP:
  - psel = 1, penable = 0, cmd_rdy = 0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - paddr/pwrite/pwdata held stable from SETUP through the end of ACCESS.
  - Wait-cycle counter increments each ACCESS cycle with pready = 0.
  - pready = 1:
    - capture rsp_rdata = prdata if read, else 0;
    - rsp_err = pslverr, rsp_timeout = 0;
    - go to RESP.
  - pready = 0 and counter == TIMEOUT-1:
    - abort, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready on the same cycle as the timeout limit: pready wins; it is a normal completion.
- RESP:
  - psel = 0, penable = 0, rsp_vld = 1.
  - rsp_* held stable until rsp_rdy.
  - On rsp_vld & rsp_rdy: go to IDLE and clear the counter.
  - rsp_vld never drops without handshake.
- Latency:
  - Zero-wait transfer: accept at cycle N, psel at N+1, penable at N+2 (pready sampled), rsp_vld at N+3.
  - With rsp_rdy held high, cmd_rdy reasserts at N+4; back-to-back throughput is 1 command per 4 cycles.
- psel/penable/paddr/pwrite/pwdata come from registers (no combinational path from cmd_* to APB).
- cmd_rdy and rsp_vld are decoded from state only.
- Outside SETUP/ACCESS, pwdata/paddr retain their last values; consumers ignore them when psel = 0.
- cmd_vld while busy is ignored (cmd_rdy = 0); the command stays pending upstream.
- Counter width = clog2(TIMEOUT+1); no wrap is possible because abort occurs before overflow.

Test Plan:
- Reset then write addr 0x10, wdata 0xDEADBEEF, pready = 1 immediately -> psel at +1, penable at +2, pwrite = 1, paddr = 0x10, rsp_vld at +3 with rsp_err = 0, rsp_rdata = 0.
- Read addr 0x04 with pready delayed 3 cycles, prdata = 0x0000A5A5 -> penable held 4 cycles, paddr stable throughout, rsp_rdata = 0x0000A5A5, rsp_err = 0.
- Read with pslverr = 1 at pready -> rsp_err = 1, rsp_timeout = 0; next command accepted normally after the rsp handshake.
- TIMEOUT = 8, pready held 0 -> psel drops after 8 ACCESS cycles, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; also hit pready exactly on the 8th cycle -> normal completion.
- rsp_rdy held 0 for 5 cycles with cmd_vld = 1 -> rsp_vld/rsp_rdata stable, cmd_rdy = 0, no new psel; release -> cmd_rdy the next cycle.
- rst_n asserted during ACCESS -> psel/penable/rsp_vld go 0 asynchronously; after release cmd_rdy = 1 and no stale response appears.
